truth_table_sweeper: RTL
========================

# truth_table_sweeper

Synthesizable stimulus-and-check stage for 3-input (parameterizable) combinational blocks such as the lab boolean functions. It sits directly upstream of the device under test, driving every input combination in turn. It also consumes the DUT output, comparing each result against an expected truth table. It reports error count, first failing vector and pass/fail, so exhaustive checks can run on the board rather than only in simulation.

## Interface
- N_IN, 3, DUT input width; sweep covers 2^N_IN vectors
- HOLD_CYCLES, 2, clock cycles each vector is held before sampling; legal range ≥1
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin sweep; sampled only in IDLE or DONE
- exp_table  input  2^N_IN  expected DUT output; bit k = expected output for input index k; must be stable while busy
- dut_out  input  1  DUT output (combinational from vec_out)
- vec_out  output  N_IN  vector driven to DUT inputs (MSB = first DUT input, e.g. a)
- busy  output  1  high while sweeping
- done  output  1  high in DONE until next start or reset
- pass  output  1  done && err_count==0
- err_count  output  N_IN+1  number of mismatching vectors
- fail_idx  output  N_IN  sweep index of first mismatch
- fail_valid  output  1  at least one mismatch recorded

## Operation
- FSM states: IDLE, APPLY, DONE.
- IDLE: start=1 → APPLY; clear idx, hold_cnt, err_count, fail_idx, fail_valid.
- APPLY: vec_out = order(idx); hold_cnt counts 0..HOLD_CYCLES-1.
  - On the edge where hold_cnt==HOLD_CYCLES-1, compare dut_out with exp_table[vec_out].
  - On mismatch, err_count+1. If fail_valid==0, latch fail_idx=idx and set fail_valid.
  - On that same edge, if idx==2^N_IN-1 → DONE; else idx+1, hold_cnt=0.
- DONE: done=1, vec_out holds last vector. start=1 → restart exactly as from IDLE.
- start while in APPLY is ignored; no abort other than rst.
- idx is N_IN bits with no wrap. Termination is by compare, so err_count max 2^N_IN fits in N_IN+1 bits.
- order(idx) = idx (binary ascending) by default.

## Timing
- Reset values: vec_out=0, busy=0, done=0, pass=0, err_count=0, fail_idx=0, fail_valid=0, state=IDLE.
- Start sampled at edge T0. busy=1 and vec_out=order(0) from T0.
- Each vector is applied for exactly HOLD_CYCLES cycles. Sweep length is 2^N_IN·HOLD_CYCLES cycles.
- done/pass assert the cycle after the final compare edge, at T0 + 2^N_IN·HOLD_CYCLES. busy deasserts in the same cycle.
- err_count/fail_* update on compare edges only; they are visible the next cycle.
- rst asserted mid-sweep: all outputs return to reset values immediately (asynchronous). A new start is required afterward.
- start held high continuously: a sweep runs and reaches DONE, then restarts on the next edge; done is high for one cycle.

## Configuration
- SWEEP_GRAY_EN defined: order(idx) = idx ^ (idx>>1), so exactly one DUT input toggles per step. fail_idx still reports the sweep index; the failing vector is order(fail_idx).
- Undefined: binary ascending order; no Gray logic synthesized.

## Structure
- Package sweep_pkg: FSM state encoding (IDLE, APPLY, DONE) and the gray-encode function.
- One sub-module, sweep_hold_counter: HOLD_CYCLES-parameterized counter with clear input and terminal-count output.
- Top contains FSM, index register, comparator and error bookkeeping.

## Test plan
- N_IN=3, HOLD=2, exp_table=8'b1001_0110, DUT = a^b^c, start pulse → vec_out steps 0..7 every 2 cycles; done at T0+16; err_count=0; pass=1; fail_valid=0.
- Same setup, dut_out stuck 0 → err_count=4 (indices 1,2,4,7); fail_idx=1; fail_valid=1; pass=0.
- rst asserted at cycle 7 of a sweep → all outputs 0 immediately; state IDLE. After a new start, a full clean sweep gives pass=1.
- start pulsed during APPLY at cycle 5 → no effect; done still at T0+16.
- SWEEP_GRAY_EN defined → vec_out sequence 0,1,3,2,6,7,5,4. With DUT a^b^c, pass=1.
- HOLD_CYCLES=1, start held high → DONE reached at T0+8, done high one cycle, then a second sweep begins with vec_out=0.

Source files
------------

// File: rtl/sweep_pkg.sv
// sweep_pkg: shared FSM state encoding and vector-ordering helper for the truth-table sweeper.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [31:0] gray_encode(input logic [31:0] v);
        return v ^ (v >> 1);
    endfunction

endpackage

// File: rtl/sweep_hold_counter.sv
// sweep_hold_counter: counts 0..HOLD_CYCLES-1 while enabled, flags the last cycle of each hold.
module sweep_hold_counter #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

    logic [W-1:0] cnt;

    assign tc = cnt == W'(HOLD_CYCLES - 1);

    // wrap to zero on terminal count so the next vector starts a fresh hold
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (clr || (en && tc))
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector to a combinational DUT and checks it against exp_table (SWEEP_GRAY_EN selects Gray ordering).
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   exp_table,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      fail_idx,
    output logic                 fail_valid
);

    state_t          state, state_nx;
    logic [N_IN-1:0] idx;
    logic            tc, launch, cmp, last, mismatch;

    assign busy     = state == APPLY;
    assign done     = state == DONE;
    assign pass     = done && err_count == '0;
    assign launch   = !busy && start;
    assign cmp      = busy && tc;
    assign last     = &idx;
    assign mismatch = dut_out != exp_table[vec_out];

`ifdef SWEEP_GRAY_EN
    assign vec_out = N_IN'(gray_encode(32'(idx)));
`else
    assign vec_out = idx;
`endif

    sweep_hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .clk (clk),
        .rst (rst),
        .clr (launch),
        .en  (busy),
        .tc  (tc)
    );

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;

    // start launches from IDLE or DONE; the final compare ends the sweep
    always_comb begin
        state_nx = state;
        state_nx = launch ? APPLY : (cmp && last) ? DONE : state;
    end

    // index stepping and error bookkeeping on compare edges; idx parks on the last vector
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx        <= '0;
            err_count  <= '0;
            fail_idx   <= '0;
            fail_valid <= 1'b0;
        end else if (launch) begin
            idx        <= '0;
            err_count  <= '0;
            fail_idx   <= '0;
            fail_valid <= 1'b0;
        end else if (cmp) begin
            idx <= last ? idx : idx + N_IN'(1);
            if (mismatch) begin
                err_count <= err_count + (N_IN+1)'(1);
                if (!fail_valid) begin
                    fail_idx   <= idx;
                    fail_valid <= 1'b1;
                end
            end
        end

endmodule
